lu_decomp_pivot: RTL

- Parametrised NxN LU decomposition engine with optional partial pivoting and a fixed-point datapath.
- Produces P·A = L·U, where L is unit lower-triangular, U is upper-triangular and P is a row permutation.
- Next generation of the 4x4 integer LU block; feeds the matrix-inversion path (forward/back substitution stages).
- Adds singular-matrix detection and a start/busy/done handshake.

---
 rtl/lu_pkg.sv | 32 +++
 rtl/lu_div_seq.sv | 77 +++++++
 rtl/lu_decomp_pivot.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/lu_pkg.sv
// rtl/lu_pkg.sv - shared state encoding and fixed-point helpers for the LU engine
package lu_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PSEARCH,
    SWAP,
    DIV,
    DWAIT,
    ELIM,
    NEXT_K,
    PACK,
    DONE
  } lu_state_e;

  // Fixed-point multiply: full-width product, arithmetic shift by frac.
  // Callers pass sign-extended W-bit operands (W <= 32) and keep the low W bits.
  function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                input logic signed [63:0] b,
                                                input int frac);
    logic signed [127:0] w_a;
    logic signed [127:0] w_b;
    logic signed [127:0] w_full;
    logic signed [127:0] w_shift;
    w_a = 128'(a);
    w_b = 128'(b);
    w_full = w_a * w_b;
    w_shift = w_full >>> frac;
    return w_shift[63:0];
  endfunction

endpackage

// File: rtl/lu_div_seq.sv
// rtl/lu_div_seq.sv - sequential signed restoring divider computing (num << FRAC) / den
module lu_div_seq #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] num,
  input  logic signed [W-1:0] den,
  output logic                valid,
  output logic signed [W-1:0] quot
);

  localparam int QW = W + FRAC;
  localparam int CW = $clog2(QW + 1);

  logic [QW-1:0] r_dvd;
  logic [QW-1:0] r_q;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_dsr;
  logic          r_neg;
  logic          r_run;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  w_num_mag;
  logic [W-1:0]  w_den_mag;
  logic [W:0]    w_trial;
  logic          w_fit;
  logic [W-1:0]  w_diff;
  logic [QW-1:0] w_q_signed;

  // Magnitudes are unsigned, so the most negative input maps to 2^(W-1).
  assign w_num_mag  = num[W-1] ? (~num + 1'b1) : num;
  assign w_den_mag  = den[W-1] ? (~den + 1'b1) : den;
  assign w_trial    = {r_rem, r_dvd[QW-1]};
  assign w_fit      = (w_trial >= {1'b0, r_dsr});
  assign w_diff     = w_trial[W-1:0] - r_dsr;
  // Magnitude quotient re-signed: truncation toward zero, low W bits kept.
  assign w_q_signed = r_neg ? (~r_q + 1'b1) : r_q;
  assign quot       = w_q_signed[W-1:0];

  // One quotient bit per cycle; valid pulses on the cycle the last bit lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd <= '0;
      r_q   <= '0;
      r_rem <= '0;
      r_dsr <= '0;
      r_neg <= 1'b0;
      r_run <= 1'b0;
      r_cnt <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        r_dvd <= {w_num_mag, {FRAC{1'b0}}};
        r_q   <= '0;
        r_rem <= '0;
        r_dsr <= w_den_mag;
        r_neg <= num[W-1] ^ den[W-1];
        r_run <= 1'b1;
        r_cnt <= CW'(QW);
      end else if (r_run) begin
        r_dvd <= r_dvd << 1;
        r_rem <= w_fit ? w_diff : w_trial[W-1:0];
        r_q   <= {r_q[QW-2:0], w_fit};
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_run <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lu_decomp_pivot.sv
// rtl/lu_decomp_pivot.sv - NxN fixed-point LU decomposition with optional partial pivoting
module lu_decomp_pivot
  import lu_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int PIVOT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N*N*W-1:0]       A_in,
  output logic                   busy,
  output logic                   done,
  output logic                   singular,
  output logic [N*N*W-1:0]       L_out,
  output logic [N*N*W-1:0]       U_out,
  output logic [N*$clog2(N)-1:0] P_out
);

  localparam int             IW     = $clog2(N);
  localparam logic [W-1:0]   ONE    = W'(1) << FRAC;
  localparam logic [IW-1:0]  LAST   = IW'(N - 1);
  localparam logic [IW-1:0]  PENULT = IW'(N - 2);

  lu_state_e r_state;
  lu_state_e w_next;

  logic signed [W-1:0] r_m [N][N];
  logic signed [W-1:0] r_l [N][N];
  logic [IW-1:0]       r_perm [N];
  logic [IW-1:0]       r_k;
  logic [IW-1:0]       r_i;
  logic [IW-1:0]       r_j;
  logic [IW-1:0]       r_p;
  logic [W-1:0]        r_pmax;
  logic                r_sing;

  logic signed [W-1:0] w_cand;
  logic signed [W-1:0] w_piv;
  logic signed [W-1:0] w_prod;
  logic signed [W-1:0] w_quot;
  logic [W-1:0]        w_mag;
  logic                w_better;
  logic                w_piv_zero;
  logic                w_div_start;
  logic                w_div_valid;
  logic [IW-1:0]       w_pbest;

  // M[i][k] serves both the pivot scan and the divider numerator.
  assign w_cand     = r_m[r_i][r_k];
  assign w_mag      = w_cand[W-1] ? (~w_cand + 1'b1) : w_cand;
  assign w_better   = (w_mag > r_pmax);
  assign w_pbest    = w_better ? r_i : r_p;
  assign w_piv      = r_m[r_k][r_k];
  assign w_piv_zero = (w_piv == '0);
  assign w_prod     = W'(fx_mul(64'(r_l[r_i][r_k]), 64'(r_m[r_k][r_j]), FRAC));

  assign busy     = (r_state != IDLE) && (r_state != DONE);
  assign done     = (r_state == DONE);
  assign singular = r_sing;

  lu_div_seq #(.W(W), .FRAC(FRAC)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (w_div_start),
    .num   (w_cand),
    .den   (w_piv),
    .valid (w_div_valid),
    .quot  (w_quot)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; the divider is launched only for a non-zero pivot.
  always_comb begin
    w_next      = r_state;
    w_div_start = 1'b0;
    unique case (r_state)
      IDLE, DONE: if (start) w_next = (PIVOT != 0) ? PSEARCH : DIV;
      PSEARCH:    if (r_i == LAST) w_next = (w_pbest != r_k) ? SWAP : DIV;
      SWAP:       w_next = DIV;
      DIV: begin
        if (w_piv_zero) begin
          w_next = NEXT_K;
        end else begin
          w_next      = DWAIT;
          w_div_start = 1'b1;
        end
      end
      DWAIT:      if (w_div_valid) w_next = ELIM;
      ELIM:       if (r_j == LAST) w_next = (r_i == LAST) ? NEXT_K : DIV;
      NEXT_K: begin
        if (r_k == PENULT) w_next = PACK;
        else               w_next = (PIVOT != 0) ? PSEARCH : DIV;
      end
      PACK:       w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  // Working matrix, multipliers, permutation and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        r_perm[r] <= '0;
        for (int c = 0; c < N; c++) begin
          r_m[r][c] <= '0;
          r_l[r][c] <= '0;
        end
      end
      r_k    <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_p    <= '0;
      r_pmax <= '0;
      r_sing <= 1'b0;
      L_out  <= '0;
      U_out  <= '0;
      P_out  <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            for (int r = 0; r < N; r++) begin
              r_perm[r] <= IW'(r);
              for (int c = 0; c < N; c++) begin
                r_m[r][c] <= A_in[(r*N+c)*W +: W];
                r_l[r][c] <= '0;
              end
            end
            r_k    <= '0;
            r_p    <= '0;
            r_pmax <= '0;
            r_sing <= 1'b0;
            r_i    <= (PIVOT != 0) ? '0 : IW'(1);
          end
        end
        PSEARCH: begin
          r_p    <= w_pbest;
          r_pmax <= w_better ? w_mag : r_pmax;
          r_i    <= (r_i == LAST) ? r_k + 1'b1 : r_i + 1'b1;
        end
        SWAP: begin
          for (int c = 0; c < N; c++) begin
            r_m[r_k][c] <= r_m[r_p][c];
            r_m[r_p][c] <= r_m[r_k][c];
            if (IW'(c) < r_k) begin
              r_l[r_k][c] <= r_l[r_p][c];
              r_l[r_p][c] <= r_l[r_k][c];
            end
          end
          r_perm[r_k] <= r_perm[r_p];
          r_perm[r_p] <= r_perm[r_k];
        end
        DIV: begin
          if (w_piv_zero) begin
            r_sing <= 1'b1;
            for (int r = 0; r < N; r++) begin
              if (IW'(r) > r_k) r_l[r][r_k] <= '0;
            end
          end
        end
        DWAIT: begin
          if (w_div_valid) begin
            r_l[r_i][r_k] <= w_quot;
            r_j           <= r_k + 1'b1;
          end
        end
        ELIM: begin
          r_m[r_i][r_j] <= r_m[r_i][r_j] - w_prod;
          r_j           <= r_j + 1'b1;
          if (r_j == LAST) begin
            r_m[r_i][r_k] <= '0;
            r_i           <= r_i + 1'b1;
          end
        end
        NEXT_K: begin
          r_k    <= r_k + 1'b1;
          r_p    <= r_k + 1'b1;
          r_pmax <= '0;
          r_i    <= (PIVOT != 0) ? r_k + 1'b1 : r_k + 1'b1 + 1'b1;
          if ((r_k == PENULT) && (r_m[N-1][N-1] == '0)) r_sing <= 1'b1;
        end
        PACK: begin
          for (int r = 0; r < N; r++) begin
            P_out[r*IW +: IW] <= r_perm[r];
            for (int c = 0; c < N; c++) begin
              L_out[(r*N+c)*W +: W] <= (r == c) ? ONE : ((r > c) ? r_l[r][c] : '0);
              U_out[(r*N+c)*W +: W] <= (r <= c) ? r_m[r][c] : '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
